// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 decode encodings, opcode prefixes and control-bundle type
package legv8_pkg;

    typedef enum logic [2:0] {
        OP_R       = 3'd0,
        OP_I       = 3'd1,
        OP_D       = 3'd2,
        OP_B       = 3'd3,
        OP_CB      = 3'd4,
        OP_IM      = 3'd5,
        OP_ILLEGAL = 3'd7
    } opType_e;

    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd10;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_ORR  = 4'd4;
    localparam logic [3:0] ALU_EOR  = 4'd9;
    localparam logic [3:0] ALU_MOVZ = 4'd13;
    localparam logic [3:0] ALU_CBZ  = 4'd7;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_EOR  = 11'b11101010000;
    localparam logic [10:0] OPC_MOVZ = 11'b11010010100;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
    localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
    localparam logic [9:0]  OPC_EORI = 10'b1101001000;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       memRead;
        logic       branch;
        logic       uncondBranch;
        logic       aluSRC;
        logic       memToReg;
        opType_e    opType;
        logic [3:0] aluControlCode;
        logic [4:0] readRegister1;
        logic [4:0] readRegister2;
        logic [4:0] writeRegister;
        logic       illegal;
    } ctrlBundle_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational LEGv8 opcode decode into a control bundle
//   instruction : 32-bit instruction word
//   bundle      : decoded flags, opType, ALU code, register fields, illegal marker
module instr_decoder
    import legv8_pkg::*;
(
    input  logic [31:0]  instruction,
    output ctrlBundle_t  bundle
);
    logic [10:0] op11;
    logic [9:0]  op10;
    assign op11 = instruction[31:21];
    assign op10 = instruction[31:22];
    always_comb begin
        bundle = '0;
        bundle.opType = OP_ILLEGAL;
        bundle.readRegister1 = instruction[9:5];
        bundle.writeRegister = instruction[4:0];
        if (op11 == OPC_LDUR || op11 == OPC_STUR) begin
            bundle.opType = OP_D;
            bundle.aluControlCode = ALU_ADD;
            bundle.aluSRC = 1'b1;
            bundle.regWrite = op11 == OPC_LDUR;
            bundle.memRead = op11 == OPC_LDUR;
            bundle.memToReg = op11 == OPC_LDUR;
            bundle.memWrite = op11 == OPC_STUR;
        end else if (op11 inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_EOR}) begin
            bundle.opType = OP_R;
            bundle.regWrite = 1'b1;
            bundle.aluControlCode = op11 == OPC_SUB ? ALU_SUB :
                                    op11 == OPC_AND ? ALU_AND :
                                    op11 == OPC_ORR ? ALU_ORR :
                                    op11 == OPC_EOR ? ALU_EOR : ALU_ADD;
        end else if (op10 inside {OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORRI, OPC_EORI}) begin
            bundle.opType = OP_I;
            bundle.regWrite = 1'b1;
            bundle.aluSRC = 1'b1;
            bundle.aluControlCode = op10 == OPC_SUBI ? ALU_SUB :
                                    op10 == OPC_ANDI ? ALU_AND :
                                    op10 == OPC_ORRI ? ALU_ORR :
                                    op10 == OPC_EORI ? ALU_EOR : ALU_ADD;
        end else if (op11 == OPC_MOVZ) begin
            bundle.opType = OP_IM;
            bundle.aluControlCode = ALU_MOVZ;
            bundle.regWrite = 1'b1;
            bundle.aluSRC = 1'b1;
        end else if (instruction[31:26] == OPC_B) begin
            bundle.opType = OP_B;
            bundle.uncondBranch = 1'b1;
        end else if (instruction[31:24] == OPC_CBZ) begin
            bundle.opType = OP_CB;
            bundle.aluControlCode = ALU_CBZ;
            bundle.branch = 1'b1;
        end
        bundle.illegal = bundle.opType == OP_ILLEGAL;
        // D and CB formats carry the second source (store data / tested reg) in Rt
        bundle.readRegister2 = bundle.opType == OP_R ? instruction[20:16] :
                               (bundle.opType == OP_D || bundle.opType == OP_CB) ? instruction[4:0] : 5'd0;
    end
endmodule

// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe: decode at acceptance, then STAGES elastic registered stages
//   clk, reset (sync, active-high), flush (drop all in-flight words)
//   in_valid/in_ready/instruction : instruction-accept handshake
//   out_valid/out_ready + decoded flags/fields/illegal : output bundle handshake
//   retiredCount (wrapping), illegalCount (saturating) : status counters
module instr_decode_pipe
    import legv8_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             regWriteFlag,
    output logic             memWriteFlag,
    output logic             memReadFlag,
    output logic             branchFlag,
    output logic             unconditionalBranchFlag,
    output logic             aluSRC,
    output logic             memToReg,
    output logic [2:0]       opType,
    output logic [3:0]       aluControlCode,
    output logic [4:0]       readRegister1,
    output logic [4:0]       readRegister2,
    output logic [4:0]       writeRegister,
    output logic             illegal,
    output logic [CNT_W-1:0] retiredCount,
    output logic [CNT_W-1:0] illegalCount
);
    ctrlBundle_t       decoded, outB;
    ctrlBundle_t       stageData [STAGES];
    logic [STAGES-1:0] stageValid, adv;
    logic              accept, retire;

    instr_decoder uDecoder (.instruction(instruction), .bundle(decoded));

    assign in_ready = !reset && !flush && (!stageValid[0] || adv[0]);
    assign accept   = in_valid && in_ready;

    for (genvar g = 0; g < STAGES; g++) begin : gStage
        logic        v, load;
        ctrlBundle_t d, src;
        if (g == 0) begin : gFirst
            assign load = accept;
            assign src  = decoded;
        end else begin : gNext
            assign load = adv[g-1];
            assign src  = stageData[g-1];
        end
        // A stage moves on if the output drains or any later stage has a hole,
        // which collapses bubbles while the output is stalled.
        if (g == STAGES - 1) begin : gLast
            assign adv[g] = v && out_ready;
        end else begin : gMid
            assign adv[g] = v && (out_ready || !(&stageValid[STAGES-1:g+1]));
        end
        always_ff @(posedge clk) begin
            if (reset || flush) v <= 1'b0;
            else if (load)      v <= 1'b1;
            else if (adv[g])    v <= 1'b0;
        end
        always_ff @(posedge clk) begin
            if (reset)     d <= '0;
            else if (load) d <= src;
        end
        assign stageValid[g] = v;
        assign stageData[g]  = d;
    end

    assign out_valid = stageValid[STAGES-1];
    assign outB      = out_valid ? stageData[STAGES-1] : '0;
    assign retire    = out_valid && out_ready && !flush;

    assign regWriteFlag            = outB.regWrite;
    assign memWriteFlag            = outB.memWrite;
    assign memReadFlag             = outB.memRead;
    assign branchFlag              = outB.branch;
    assign unconditionalBranchFlag = outB.uncondBranch;
    assign aluSRC                  = outB.aluSRC;
    assign memToReg                = outB.memToReg;
    assign opType                  = outB.opType;
    assign aluControlCode          = outB.aluControlCode;
    assign readRegister1           = outB.readRegister1;
    assign readRegister2           = outB.readRegister2;
    assign writeRegister           = outB.writeRegister;
    assign illegal                 = outB.illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            retiredCount <= '0;
            illegalCount <= '0;
        end else begin
            if (retire) retiredCount <= retiredCount + 1'b1;
            if (retire && outB.illegal && !(&illegalCount)) illegalCount <= illegalCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb_instr_decode_pipe: directed and randomized checks of instr_decode_pipe (STAGES=2 and 3)
module tb_instr_decode_pipe;
    localparam logic [31:0] W_LDUR = 32'hF84F0149;
    localparam logic [31:0] W_ADD  = 32'h8B150289;
    localparam logic [31:0] W_SUBI = 32'hD10006D6;
    localparam logic [31:0] W_B    = 32'h14000002;

    localparam logic [29:0] E_LDUR = {1'b0, 3'd2, 4'd2, 5'd10, 5'd9, 5'd9, 7'b1010011};
    localparam logic [29:0] E_ADD  = {1'b0, 3'd0, 4'd2, 5'd20, 5'd21, 5'd9, 7'b1000000};
    localparam logic [29:0] E_SUBI = {1'b0, 3'd1, 4'd10, 5'd22, 5'd0, 5'd22, 7'b1000010};
    localparam logic [29:0] E_B    = {1'b0, 3'd3, 4'd0, 5'd0, 5'd0, 5'd2, 7'b0000100};
    localparam logic [29:0] E_ILL0 = {1'b1, 3'd7, 26'd0};

    // Opcode table: prefix value, prefix length, opType, ALU code, flags
    // (regWrite, memWrite, memRead, branch, uncondBranch, aluSRC, memToReg)
    localparam int PFX [15] = '{'h7C2, 'h7C0, 'h458, 'h658, 'h450, 'h550, 'h750,
                                'h244, 'h344, 'h248, 'h2C8, 'h348, 'h694, 'h05, 'hB4};
    localparam int LEN [15] = '{11, 11, 11, 11, 11, 11, 11, 10, 10, 10, 10, 10, 11, 6, 8};
    localparam int TYP [15] = '{2, 2, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 5, 3, 4};
    localparam int ALU [15] = '{2, 2, 2, 10, 6, 4, 9, 2, 10, 6, 4, 9, 13, 0, 7};
    localparam int FLG [15] = '{'b1010011, 'b0100010, 'b1000000, 'b1000000, 'b1000000,
                                'b1000000, 'b1000000, 'b1000010, 'b1000010, 'b1000010,
                                'b1000010, 'b1000010, 'b1000010, 'b0000100, 'b0001000};

    logic              clk = 1'b0;
    logic              reset, flush, inValid, outReady;
    logic [31:0]       instruction;
    logic [1:0]        inReady, outValid;
    logic [1:0][29:0]  gotB;
    logic [1:0][15:0]  retCnt, illCnt;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    for (genvar s = 0; s < 2; s++) begin : gDut
        logic       rw, mw, mr, br, ub, as, mtr, ill;
        logic [2:0] ot;
        logic [3:0] ac;
        logic [4:0] r1, r2, wr;
        instr_decode_pipe #(.STAGES(s + 2), .CNT_W(16)) dut (
            .clk(clk), .reset(reset), .flush(flush),
            .in_valid(inValid), .in_ready(inReady[s]), .instruction(instruction),
            .out_valid(outValid[s]), .out_ready(outReady),
            .regWriteFlag(rw), .memWriteFlag(mw), .memReadFlag(mr), .branchFlag(br),
            .unconditionalBranchFlag(ub), .aluSRC(as), .memToReg(mtr),
            .opType(ot), .aluControlCode(ac), .readRegister1(r1), .readRegister2(r2),
            .writeRegister(wr), .illegal(ill),
            .retiredCount(retCnt[s]), .illegalCount(illCnt[s])
        );
        assign gotB[s] = {ill, ot, ac, r1, r2, wr, rw, mw, mr, br, ub, as, mtr};
    end

    function automatic logic [29:0] model(input logic [31:0] w);
        for (int i = 0; i < 15; i++)
            if ((w >> (32 - LEN[i])) == 32'(PFX[i]))
                return {1'b0, 3'(TYP[i]), 4'(ALU[i]), w[9:5],
                        TYP[i] == 0 ? w[20:16] : (TYP[i] == 2 || TYP[i] == 4) ? w[4:0] : 5'd0,
                        w[4:0], 7'(FLG[i])};
        return {1'b1, 3'd7, 4'd0, w[9:5], 5'd0, w[4:0], 7'd0};
    endfunction

    function automatic logic [31:0] randWord();
        int i;
        logic [31:0] p;
        i = $urandom_range(0, 17);
        if (i >= 15) return $urandom();
        p = 32'(PFX[i]) << (32 - LEN[i]);
        return p | ($urandom() >> LEN[i]);
    endfunction

    // One cycle: apply inputs just after the edge, return at the following negedge
    task automatic cyc(input logic rs, input logic fl, input logic v, input logic [31:0] w, input logic rdy);
        @(posedge clk);
        #1;
        reset = rs; flush = fl; inValid = v; instruction = w; outReady = rdy;
        #4;
    endtask

    task automatic test_reset();
        cyc(1, 0, 1, W_ADD, 1);
        checks++;
        if (inReady !== 2'b00) begin errors++; $display("FAIL reset_in_ready got %b want 00", inReady); end
        cyc(0, 0, 0, 0, 1);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (outValid[s] !== 1'b0 || gotB[s] !== 30'd0) begin
                errors++; $display("FAIL reset_outputs dut%0d got v=%b b=%h want 0", s, outValid[s], gotB[s]);
            end
            checks++;
            if (retCnt[s] !== 16'd0 || illCnt[s] !== 16'd0) begin
                errors++; $display("FAIL reset_counters dut%0d got %0d/%0d want 0/0", s, retCnt[s], illCnt[s]);
            end
            checks++;
            if (inReady[s] !== 1'b1) begin errors++; $display("FAIL reset_release_ready dut%0d got %b want 1", s, inReady[s]); end
        end
    endtask

    task automatic test_ldur_latency();
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, W_LDUR, 1);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (outValid[0] !== 1'b0) begin errors++; $display("FAIL ldur_early got out_valid=%b want 0", outValid[0]); end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (outValid[0] !== 1'b1 || gotB[0] !== E_LDUR) begin
            errors++; $display("FAIL ldur_bundle got v=%b b=%h want v=1 b=%h", outValid[0], gotB[0], E_LDUR);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, W_ADD, 1);
        cyc(0, 0, 1, W_SUBI, 1);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (outValid[0] !== 1'b1 || gotB[0] !== E_ADD) begin
            errors++; $display("FAIL b2b_add got v=%b b=%h want v=1 b=%h", outValid[0], gotB[0], E_ADD);
        end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (outValid[0] !== 1'b1 || gotB[0] !== E_SUBI) begin
            errors++; $display("FAIL b2b_subi got v=%b b=%h want v=1 b=%h", outValid[0], gotB[0], E_SUBI);
        end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (outValid[0] !== 1'b0 || retCnt[0] !== 16'd2) begin
            errors++; $display("FAIL b2b_done got v=%b retired=%0d want v=0 retired=2", outValid[0], retCnt[0]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] words [3];
        int acc;
        words = '{W_ADD, W_SUBI, W_LDUR};
        acc = 0;
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, words[acc < 3 ? acc : 2], 0);
            if (inReady[1]) acc++;
            if (k >= 3) begin
                checks++;
                if (outValid[1] !== 1'b1 || gotB[1] !== E_ADD) begin
                    errors++; $display("FAIL stall_hold cycle%0d got v=%b b=%h want v=1 b=%h", k, outValid[1], gotB[1], E_ADD);
                end
            end
        end
        checks++;
        if (acc != 3) begin errors++; $display("FAIL stall_accepted got %0d want 3", acc); end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 1);
            checks++;
            if (outValid[1] !== 1'b1 || gotB[1] !== model(words[k])) begin
                errors++; $display("FAIL stall_drain%0d got v=%b b=%h want v=1 b=%h", k, outValid[1], gotB[1], model(words[k]));
            end
        end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (retCnt[1] !== 16'd3 || outValid[1] !== 1'b0) begin
            errors++; $display("FAIL stall_retired got %0d v=%b want 3 v=0", retCnt[1], outValid[1]);
        end
    endtask

    task automatic test_illegal();
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (outValid[0] !== 1'b1 || gotB[0] !== E_ILL0 || illCnt[0] !== 16'd0) begin
            errors++; $display("FAIL illegal_bundle got v=%b b=%h cnt=%0d want v=1 b=%h cnt=0", outValid[0], gotB[0], illCnt[0], E_ILL0);
        end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (illCnt[0] !== 16'd1 || retCnt[0] !== 16'd1) begin
            errors++; $display("FAIL illegal_count got ill=%0d ret=%0d want 1/1", illCnt[0], retCnt[0]);
        end
    endtask

    task automatic test_flush();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, W_ADD, 0);
        cyc(0, 0, 1, W_SUBI, 0);
        cyc(0, 1, 1, W_LDUR, 1);
        checks++;
        if (inReady[0] !== 1'b0 || outValid[0] !== 1'b1) begin
            errors++; $display("FAIL flush_cycle got ready=%b v=%b want ready=0 v=1", inReady[0], outValid[0]);
        end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (outValid[0] !== 1'b0 || retCnt[0] !== 16'd0) begin
            errors++; $display("FAIL flush_after got v=%b retired=%0d want v=0 retired=0", outValid[0], retCnt[0]);
        end
        cyc(0, 0, 1, W_B, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (outValid[0] !== 1'b1 || gotB[0] !== E_B) begin
            errors++; $display("FAIL flush_branch got v=%b b=%h want v=1 b=%h", outValid[0], gotB[0], E_B);
        end
    endtask

    task automatic test_reset_midstream();
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h0, 1);
        cyc(0, 0, 1, W_ADD, 0);
        cyc(0, 0, 1, W_LDUR, 1);
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (outValid[0] !== 1'b1 || retCnt[0] !== 16'd1 || illCnt[0] !== 16'd1) begin
            errors++; $display("FAIL midreset_pre got v=%b ret=%0d ill=%0d want 1/1/1", outValid[0], retCnt[0], illCnt[0]);
        end
        cyc(1, 1, 1, W_SUBI, 0);
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (outValid[0] !== 1'b0 || retCnt[0] !== 16'd0 || illCnt[0] !== 16'd0 || gotB[0] !== 30'd0) begin
            errors++; $display("FAIL midreset_post got v=%b ret=%0d ill=%0d b=%h want all 0", outValid[0], retCnt[0], illCnt[0], gotB[0]);
        end
    endtask

    task automatic test_random();
        logic [29:0] q [2][$];
        logic [29:0] expB, popped;
        int          rc [2], ic [2];
        logic        rs, fl, v, rdy, expReady;
        logic [31:0] w;
        cyc(1, 0, 0, 0, 0);
        rc = '{0, 0};
        ic = '{0, 0};
        for (int n = 0; n < 800; n++) begin
            rs  = $urandom_range(0, 149) == 0;
            fl  = $urandom_range(0, 29) == 0;
            v   = $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 2) != 0;
            w   = randWord();
            cyc(rs, fl, v, w, rdy);
            for (int s = 0; s < 2; s++) begin
                expB = outValid[s] ? (q[s].size() > 0 ? q[s][0] : '1) : 30'd0;
                checks++;
                if (gotB[s] !== expB || (outValid[s] && q[s].size() == 0)) begin
                    errors++; $display("FAIL rand_bundle dut%0d cyc%0d got v=%b b=%h want %h (inflight %0d)", s, n, outValid[s], gotB[s], expB, q[s].size());
                end
                expReady = !rs && !fl && (q[s].size() < s + 2 || rdy);
                checks++;
                if (inReady[s] !== expReady) begin
                    errors++; $display("FAIL rand_ready dut%0d cyc%0d got %b want %b", s, n, inReady[s], expReady);
                end
                checks++;
                if (retCnt[s] !== 16'(rc[s]) || illCnt[s] !== 16'(ic[s])) begin
                    errors++; $display("FAIL rand_counters dut%0d cyc%0d got %0d/%0d want %0d/%0d", s, n, retCnt[s], illCnt[s], rc[s], ic[s]);
                end
                if (rs) begin
                    q[s].delete();
                    rc[s] = 0;
                    ic[s] = 0;
                end else if (fl) begin
                    q[s].delete();
                end else begin
                    if (outValid[s] && rdy && q[s].size() > 0) begin
                        popped = q[s].pop_front();
                        rc[s] = (rc[s] + 1) % 65536;
                        if (popped[29] && ic[s] < 65535) ic[s]++;
                    end
                    if (v && inReady[s]) q[s].push_back(model(w));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; inValid = 1'b0; instruction = '0; outReady = 1'b0;
        test_reset();
        test_ldur_latency();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
